note_slot_scheduler: RTL

Allocates on-screen note slots for the Taiko note pipeline. It accepts spawn requests (note colour) from the beatmap sequencer through a valid/ready handshake and picks the lowest-index free slot among the parallel note-block instances. It issues that slot a one-cycle start pulse with the latched colour, then tracks each slot's occupancy from the slot's reported state. It replaces the hard-wired switch-to-start wiring in the top level and sits between the beatmap source and the note-block/counter array.

---
 rtl/note_slot_scheduler_pkg.sv | 18 +
 rtl/note_slot_prio_enc.sv | 29 ++
 rtl/note_slot_scheduler.sv | 100 ++++++++++
 3 files changed

// File: rtl/note_slot_scheduler_pkg.sv
// Shared encodings and defaults for the note slot scheduler.
`default_nettype none

package note_slot_scheduler_pkg;

  localparam logic [1:0] SLOT_IDLE = 2'b00;

  localparam int DEF_NUM_SLOTS = 15;
  localparam int DEF_COLOUR_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/note_slot_prio_enc.sv
// Lowest-index priority encoder: free vector -> one-hot grant plus any_free.
`default_nettype none

module note_slot_prio_enc #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] free,
  output logic [WIDTH-1:0] grant,
  output logic             any_free
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (free[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_free = |free;

endmodule

`default_nettype wire

// File: rtl/note_slot_scheduler.sv
// Spawn-request scheduler: grants the lowest free note slot, pulses its start
// line with the latched colour, and tracks reservations until the slot acks.
`default_nettype none

module note_slot_scheduler
  import note_slot_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int COLOUR_W    = DEF_COLOUR_W,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          spawn_valid,
  input  logic [COLOUR_W-1:0]           spawn_colour,
  output logic                          spawn_ready,
  input  logic [2*NUM_SLOTS-1:0]        slot_state,
  output logic [NUM_SLOTS-1:0]          slot_start,
  output logic [COLOUR_W*NUM_SLOTS-1:0] slot_colour,
  output logic [NUM_SLOTS-1:0]          busy_mask,
  output logic [7:0]                    spawn_count,
  output logic                          ack_error
);

  localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

  sched_state_t         state, state_next;
  logic [NUM_SLOTS-1:0] occupied, reserved, free, grant, grant_now, timeout;
  logic                 any_free, accept;

  assign free      = ~occupied & ~reserved;
  assign busy_mask = ~free;
  assign accept    = spawn_valid & spawn_ready;
  assign grant_now = accept ? grant : '0;

  note_slot_prio_enc #(.WIDTH(NUM_SLOTS)) u_prio (
    .free     (free),
    .grant    (grant),
    .any_free (any_free)
  );

  // spawn_ready is forced low during reset since free slots already read as idle.
  always_comb begin
    state_next  = state;
    spawn_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        spawn_ready = any_free & ~reset;
        if (spawn_valid && spawn_ready) state_next = ST_ISSUE;
      end
      ST_ISSUE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      slot_start  <= '0;
      spawn_count <= 8'd0;
      ack_error   <= 1'b0;
    end else begin
      state      <= state_next;
      slot_start <= grant_now;
      if (accept) spawn_count <= spawn_count + 8'd1;
      if (|timeout) ack_error <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic               res_r;
    logic [TIMER_W-1:0] timer_r;
    logic [COLOUR_W-1:0] colour_r;

    assign occupied[i] = (slot_state[2*i +: 2] != SLOT_IDLE);
    assign reserved[i] = res_r;
    assign timeout[i]  = res_r & ~occupied[i] & (timer_r == TIMER_LAST);
    assign slot_colour[COLOUR_W*i +: COLOUR_W] = colour_r;

    // A new grant takes priority over any reservation release in the same cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        res_r    <= 1'b0;
        timer_r  <= '0;
        colour_r <= '0;
      end else if (grant_now[i]) begin
        res_r    <= 1'b1;
        timer_r  <= '0;
        colour_r <= spawn_colour;
      end else if (res_r) begin
        if (occupied[i] || timeout[i]) res_r   <= 1'b0;
        else                           timer_r <= timer_r + TIMER_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
